freq_div_prog: RTL and testbench
================================

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 18, counter and divisor width in bits.
REQ-003 Parameter DEFAULT_DIV, default 250000, divisor loaded into every channel at reset (must fit CNT_W).
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clock.
REQ-006 enable  input  1  global count enable; low freezes all counters and outputs.
REQ-007 load_valid  input  1  divisor/mode load request.
REQ-008 load_ch  input  max(1,clog2(NUM_CH))  target channel of load.
REQ-009 load_div  input  CNT_W  new divisor; 0 = channel disabled.
REQ-010 load_mode  input  1  0 = toggle (square wave), 1 = pulse (one-cycle strobe).
REQ-011 load_ready  output  1  load accepted this cycle when load_valid and load_ready both high.
REQ-012 clk_out  output  NUM_CH  per-channel divided output.
REQ-013 tick  output  NUM_CH  per-channel one-cycle strobe at each counter wrap, registered.

Function
REQ-014 Each channel SHALL hold active divisor div, active mode, counter cnt, shadow divisor/mode, and pending flag.
REQ-015 With enable high and div != 0, cnt SHALL increment by 1 per cycle; when cnt >= div, cnt SHALL wrap to 0 that cycle (wrap event).
REQ-016 Wrap period SHALL be div+1 cycles; tick SHALL be high exactly the cycle after each wrap event, low otherwise.
REQ-017 Toggle mode: clk_out SHALL invert on each wrap event; output period 2*(div+1) cycles, 50% duty.
REQ-018 Pulse mode: clk_out SHALL equal tick.
REQ-019 div == 0: cnt held at 0, clk_out and tick held 0, no wrap events.
REQ-020 enable low: cnt, clk_out, and shadow state SHALL hold; tick SHALL be 0; loads SHALL still be accepted.
REQ-021 load_ready SHALL be high when pending[load_ch] == 0, computed combinationally from load_ch; load_ch >= NUM_CH SHALL give load_ready = 0.
REQ-022 On accept, load_div/load_mode SHALL be written to the target channel shadow and pending set.
REQ-023 A pending update SHALL be applied at the channel's next wrap event: div/mode take shadow values, pending clears, cnt restarts at 0.
REQ-024 If the channel's active div is 0, a pending update SHALL be applied the cycle after accept.
REQ-025 On apply, if mode changes, clk_out SHALL be forced 0 that cycle instead of toggling.
REQ-026 Accept and wrap on the same channel in the same cycle: wrap proceeds with old settings; new settings apply at the following wrap.
REQ-027 Applying div == 0 SHALL clear clk_out to 0.
REQ-028 Channels SHALL be fully independent; a load to one channel SHALL not disturb any other channel's count or phase.
REQ-029 No combinational path from any input to clk_out or tick.

Reset
REQ-030 While reset is low: cnt = 0, clk_out = 0, tick = 0, div = DEFAULT_DIV, mode = toggle, pending = 0, shadow = DEFAULT_DIV/toggle, for every channel.
REQ-031 Reset asserted mid-count or with a load pending SHALL discard the pending load and restart all channels in phase.
REQ-032 load_ready is combinational and SHALL read 1 for valid load_ch while reset is low.

Verification
REQ-033 Reset release, enable = 1, defaults: every clk_out first rises 250001 cycles after release, falls 250001 later; tick pulses every 250001 cycles.
REQ-034 Load ch1 div = 4 toggle: ch1 switches at its next wrap, then period 10 cycles, duty 5/5; ch0, ch2, ch3 unaffected.
REQ-035 Load ch2 div = 2 pulse, then second load to ch2 before wrap: load_ready(ch2) = 0 until apply; afterwards clk_out[2] = tick[2], high 1 of every 3 cycles.
REQ-036 Load ch3 div = 0: clk_out[3]/tick[3] go 0 at next wrap; later load div = 1 applies next cycle, clk_out[3] period 4.
REQ-037 Drop enable for 7 cycles with ch1 at div = 4: cnt and clk_out frozen, tick silent, phase resumes with cycle count extended by exactly 7.
REQ-038 Assert reset mid-period with a pending load: all outputs 0 immediately, pending discarded, all channels resume with DEFAULT_DIV in phase.

Source files
------------

// File: rtl/freq_div_prog_if.sv
// freq_div_prog_if: divisor/mode load handshake between a controller and the divider bank
interface freq_div_prog_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 18
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic             load_valid;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_div;
  logic             load_mode;
  logic             load_ready;
  modport master(output load_valid, load_ch, load_div, load_mode, input load_ready);
  modport slave(input load_valid, load_ch, load_div, load_mode, output load_ready);
endinterface

// File: rtl/freq_div_prog.sv
// freq_div_prog: bank of programmable clock dividers with shadowed divisor/mode reloads
module freq_div_prog #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 18,
  parameter int DEFAULT_DIV = 250000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  freq_div_prog_if.slave    load,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] div [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] sh_div [NUM_CH];
  logic [NUM_CH-1:0] mode, sh_mode, pend, acc, wrap, apply;
  // A load is ready only for an in-range channel with no update already queued
  always_comb begin
    load.load_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (load.load_ch == CH_W'(i)) load.load_ready = !pend[i];
  end
  // Per-channel wrap, apply and accept decode; a disabled channel applies immediately
  always_comb begin
    wrap  = '0;
    apply = '0;
    acc   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = div[i] != '0 && cnt[i] >= div[i];
      apply[i] = enable && pend[i] && (wrap[i] || div[i] == '0);
      acc[i]   = load.load_valid && !pend[i] && load.load_ch == CH_W'(i);
    end
  end
  // Counters, registered outputs and shadow/pending update per channel
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      clk_out <= '0;
      tick    <= '0;
      mode    <= '0;
      sh_mode <= '0;
      pend    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div[i]    <= DEF;
        cnt[i]    <= '0;
        sh_div[i] <= DEF;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i]) begin
          sh_div[i]  <= load.load_div;
          sh_mode[i] <= load.load_mode;
          pend[i]    <= 1'b1;
        end
        if (!enable) begin
          tick[i]    <= 1'b0;
          clk_out[i] <= clk_out[i] & ~mode[i];
        end else if (apply[i]) begin
          div[i]     <= sh_div[i];
          mode[i]    <= sh_mode[i];
          pend[i]    <= 1'b0;
          cnt[i]     <= '0;
          tick[i]    <= wrap[i];
          clk_out[i] <= (!wrap[i] || sh_mode[i] != mode[i] || sh_div[i] == '0) ? 1'b0 : mode[i] | ~clk_out[i];
        end else begin
          cnt[i]     <= (wrap[i] || div[i] == '0) ? '0 : cnt[i] + 1'b1;
          tick[i]    <= wrap[i];
          clk_out[i] <= wrap[i] ? (mode[i] | ~clk_out[i]) : (clk_out[i] & ~mode[i] & (div[i] != '0));
        end
      end
    end
endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: table, directed and random checks of freq_div_prog against a wrap-count model
module tb_freq_div_prog;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int DEF    = 12;
  localparam int CH_W   = 3;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [NUM_CH-1:0] clk_out, tick;
  freq_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) lif ();
  freq_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(lif), .clk_out(clk_out), .tick(tick));
  always #5 clock = ~clock;

  typedef struct { int ch; int dv; bit md; bit rdy; logic [NUM_CH-1:0] tk; } vec_t;
  vec_t tbl[9];
  int tests = 0;
  int fails = 0;

  // Reference model: outputs derived from wrap counts since the last settings change
  int m_div[NUM_CH], m_age[NUM_CH], m_nw[NUM_CH], m_sdiv[NUM_CH];
  bit [NUM_CH-1:0] m_mode, m_smode, m_pend, m_tick, m_force;

  function automatic void m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = DEF; m_age[i] = 0; m_nw[i] = 0; m_sdiv[i] = DEF;
    end
    m_mode = '0; m_smode = '0; m_pend = '0; m_tick = '0; m_force = '0;
  endfunction

  function automatic bit m_ready(int ch);
    return (ch < NUM_CH) ? !m_pend[ch] : 1'b0;
  endfunction

  function automatic logic [NUM_CH-1:0] m_clk();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = m_force[i] ? 1'b0 : m_mode[i] ? m_tick[i] : (m_nw[i] % 2 == 1);
    return v;
  endfunction

  function automatic void m_step(bit en, bit lv, int ch, int dv, bit md);
    bit acc = lv && m_ready(ch);
    for (int i = 0; i < NUM_CH; i++) begin
      bit wr, ap;
      m_force[i] = 1'b0;
      if (!en) m_tick[i] = 1'b0;
      else begin
        wr = m_div[i] != 0 && m_age[i] >= m_div[i];
        ap = m_pend[i] && (wr || m_div[i] == 0);
        m_tick[i] = wr;
        if (wr) m_nw[i]++;
        m_age[i] = (wr || m_div[i] == 0) ? 0 : m_age[i] + 1;
        if (ap) begin
          if (m_smode[i] != m_mode[i] || m_sdiv[i] == 0) begin
            m_nw[i] = 0;
            m_force[i] = 1'b1;
          end
          m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 1'b0; m_age[i] = 0;
        end
      end
    end
    if (acc) begin
      m_sdiv[ch] = dv; m_smode[ch] = md; m_pend[ch] = 1'b1;
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 50) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit lv, int ch, int dv, bit md);
    lif.load_valid = lv;
    lif.load_ch    = CH_W'(ch);
    lif.load_div   = CNT_W'(dv);
    lif.load_mode  = md;
  endtask

  task automatic cyc();
    #1;
    chk("load_ready", lif.load_ready, m_ready(int'(lif.load_ch)));
    @(posedge clock);
    if (reset) m_step(enable, lif.load_valid, int'(lif.load_ch), int'(lif.load_div), lif.load_mode);
    #1;
    chk("clk_out", clk_out, m_clk());
    chk("tick", tick, m_tick);
  endtask

  task automatic wait_level(int ch, bit lvl, output int n);
    n = 0;
    do begin cyc(); n++; end while (clk_out[ch] !== lvl && n < 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h, l, k, tk0, tk3;
    int hi[NUM_CH];
    tbl[0] = '{0, 5, 1'b0, 1'b1, '0};
    tbl[1] = '{0, 3, 1'b0, 1'b0, '0};
    tbl[2] = '{1, 4, 1'b0, 1'b1, '0};
    tbl[3] = '{2, 2, 1'b1, 1'b1, '0};
    tbl[4] = '{2, 6, 1'b0, 1'b0, '0};
    tbl[5] = '{3, 0, 1'b0, 1'b1, '0};
    tbl[6] = '{6, 1, 1'b0, 1'b0, '0};
    tbl[7] = '{5, 3, 1'b1, 1'b0, '0};
    tbl[8] = '{4, 7, 1'b1, 1'b1, '0};
    m_reset();
    drive(0, 0, 0, 0);
    repeat (3) cyc();
    reset = 1'b1;
    enable = 1'b1;
    // default divisor: first rise and fall each DEF+1 cycles, all channels in phase
    wait_level(0, 1, n);
    chk("first_rise", n, DEF + 1);
    chk("in_phase", clk_out, {NUM_CH{1'b1}});
    n = 0; tk0 = 0;
    do begin cyc(); n++; tk0 += tick[0]; end while (clk_out[0] !== 1'b0 && n < 100);
    chk("first_fall", n, DEF + 1);
    chk("tick_once", tk0, 1);
    // table of load attempts, all before the next wrap
    for (int i = 0; i < 9; i++) begin
      drive(1, tbl[i].ch, tbl[i].dv, tbl[i].md);
      #1;
      chk("tbl_ready", lif.load_ready, tbl[i].rdy);
      cyc();
      chk("tbl_tick", tick, tbl[i].tk);
    end
    drive(0, 0, 0, 0);
    repeat (20) cyc();
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    tk3 = 0;
    repeat (30) begin
      cyc();
      for (int i = 0; i < NUM_CH; i++) hi[i] += clk_out[i];
      tk3 += tick[3];
    end
    chk("ch1_hi30", hi[1], 15);
    chk("ch2_hi30", hi[2], 10);
    chk("ch3_hi30", hi[3], 0);
    chk("ch3_tick30", tk3, 0);
    wait_level(1, 0, n);
    wait_level(1, 1, n);
    wait_level(1, 0, h);
    chk("ch1_high", h, 5);
    wait_level(1, 1, l);
    chk("ch1_low", l, 5);
    // ch3 from disabled to div 1: applies next cycle, period 4
    drive(1, 3, 1, 0);
    cyc();
    drive(0, 0, 0, 0);
    repeat (2) cyc();
    h = 0;
    repeat (20) begin cyc(); h += clk_out[3]; end
    chk("ch3_hi20", h, 10);
    // enable dropped 7 cycles while ch1 is high stretches that phase by 7
    wait_level(1, 0, n);
    wait_level(1, 1, n);
    h = 1; k = 0;
    while (k < 40) begin
      enable = !(k >= 1 && k < 8);
      cyc();
      if (clk_out[1] !== 1'b1) break;
      h++; k++;
    end
    enable = 1'b1;
    chk("ch1_frozen_high", h, 12);
    // async reset with a pending load discards it and restarts in phase
    drive(1, 0, 9, 1);
    cyc();
    drive(0, 0, 0, 0);
    #1;
    chk("pend_ready", lif.load_ready, 0);
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", lif.load_ready, 1);
    repeat (2) cyc();
    reset = 1'b1;
    wait_level(0, 1, n);
    chk("rerise", n, DEF + 1);
    chk("rephase", clk_out, {NUM_CH{1'b1}});
    // randomized loads, enables and occasional resets
    repeat (3000) begin
      enable = ($urandom % 8) != 0;
      drive(($urandom % 3) == 0, $urandom % 8, $urandom % 8, $urandom % 2);
      if ($urandom % 400 == 0) begin
        #2;
        reset = 1'b0;
        m_reset();
        cyc();
        reset = 1'b1;
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
